// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: multiplies finish in the accept cycle via one combinational multiply.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0]   ZERO_X  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ZERO_2X = {(2*XLEN){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sgn1_s, sgn2_s;
    logic [XLEN-1:0]   mag1_s, mag2_s;
    logic              ovf_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN:0]     div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_s;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
        abs_val = neg ? (ZERO_X - v) : v;
    endfunction

    // Operand signedness, magnitudes and the signed-overflow case, decoded in the accept cycle
    always_comb begin
        case (op_i)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1_s = operand1_i[XLEN-1];
                sgn2_s = operand2_i[XLEN-1];
            end
            OP_MULHSU: begin
                sgn1_s = operand1_i[XLEN-1];
                sgn2_s = 1'b0;
            end
            default: begin
                sgn1_s = 1'b0;
                sgn2_s = 1'b0;
            end
        endcase
        mag1_s = abs_val(operand1_i, sgn1_s);
        mag2_s = abs_val(operand2_i, sgn2_s);
        ovf_s  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (operand1_i == MIN_X) && (operand2_i == ONES_X);
    end

    // One iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_q[XLEN-1:1]};
        div_shift_s = acc_q[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, opb_q};
        if (div_diff_s[XLEN]) begin
            div_next_s = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result-half selection once iteration is complete
    always_comb begin
        prod_s = neg_q ? (ZERO_2X - acc_q) : acc_q;
        quot_s = neg_q ? (ZERO_X - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_s  = rem_neg_q ? (ZERO_X - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            fix_s = op_q[1] ? rem_s : quot_s;
        end else if (op_q[1:0] == OP_MUL[1:0]) begin
            fix_s = prod_s[XLEN-1:0];
        end else begin
            fix_s = prod_s[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a_s, fast_b_s, fast_p_s;
    logic [XLEN-1:0]   fast_res_s;

    // Single-cycle multiply on sign/zero-extended operands
    always_comb begin
        fast_a_s   = {{XLEN{sgn1_s}}, operand1_i};
        fast_b_s   = {{XLEN{sgn2_s}}, operand2_i};
        fast_p_s   = fast_a_s * fast_b_s;
        fast_res_s = (op_i == OP_MUL) ? fast_p_s[XLEN-1:0] : fast_p_s[2*XLEN-1:XLEN];
    end
`endif

    // Next-state logic; kill overrides everything and leaves result untouched
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        if (kill_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_d      = op_i;
                        opb_d     = mag2_s;
                        acc_d     = {ZERO_X, mag1_s};
                        neg_d     = sgn1_s ^ sgn2_s;
                        rem_neg_d = sgn1_s;
                        cnt_d     = {CW{1'b0}};
                        if (op_i[2] && (operand2_i == ZERO_X)) begin
                            result_d = op_i[1] ? operand1_i : ONES_X;
                            state_d  = S_DONE;
                        end else if (ovf_s) begin
                            result_d = op_i[1] ? ZERO_X : operand1_i;
                            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!op_i[2]) begin
                            result_d = fast_res_s;
                            state_d  = S_DONE;
`endif
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? div_next_s : mul_next_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    result_d = fix_s;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            op_q      <= 3'b000;
            opb_q     <= ZERO_X;
            acc_q     <= ZERO_2X;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= ZERO_X;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE) & ~kill_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (XLEN=32); follows MULDIV_FAST_MUL_EN if defined.
module tb_muldiv_iter;
    localparam int XLEN = 32;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] operand1_i;
    logic [XLEN-1:0] operand2_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] last_res;

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .kill_i     (kill_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted request in cycle 0; returns sampling in cycle 1
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i       = op;
        operand1_i = a;
        operand2_i = b;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
    endtask

    // Wait for done_o, checking latency/result; optionally poke start while busy or in DONE
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat,
                             input bit poke_busy, input bit poke_done);
        int cyc = 1;
        while (done_o !== 1'b1 && cyc < 100) begin
            if (poke_busy && cyc == 5) begin
                op_i       = 3'b111;
                operand1_i = 32'd1;
                operand2_i = 32'd1;
                start_i    = 1'b1;
            end
            step();
            start_i = 1'b0;
            cyc++;
        end
        check_val({tag, "_lat"}, cyc, exp_lat);
        check_val(tag, result_o, exp_res);
        last_res = exp_res;
        if (poke_done) begin
            op_i       = 3'b101;
            operand1_i = 32'd50;
            operand2_i = 32'd5;
            start_i    = 1'b1;
        end
        step();
        start_i = 1'b0;
        check_val({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        check_val({tag, "_hold"}, result_o, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        launch(op, a, b);
        wait_done(tag, exp_res, exp_lat, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        start_i    = 1'b0;
        kill_i     = 1'b0;
        op_i       = 3'b000;
        operand1_i = 32'd0;
        operand2_i = 32'd0;
        last_res   = 32'd0;
        step();
        step();
        check_val("rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("rst_done", {31'd0, done_o}, 32'd0);
        check_val("rst_result", result_o, 32'd0);
        rst = 1'b1;
        step();

        run_op("mul_neg",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu",      3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_small",  3'b001, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu_pow",   3'b011, 32'h8000_0000, 32'd4,        32'd2,         MUL_LAT);
        run_op("mul_shift",   3'b000, 32'h1234_5678, 32'h10,       32'h2345_6780, MUL_LAT);
        run_op("div_neg",     3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_neg",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
        run_op("div_negdiv",  3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_negdiv",  3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         DIV_LAT);
        run_op("remu",        3'b111, 32'd100,      32'd7,        32'd2,         DIV_LAT);
        run_op("div_by0",     3'b100, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 1);
        run_op("rem_by0",     3'b110, 32'd5,        32'd0,        32'd5,         1);
        run_op("divu_by0",    3'b101, 32'd9,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("remu_by0",    3'b111, 32'd9,        32'd0,        32'd9,         1);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // start while busy must not disturb DIVU 100/7; start in DONE must be dropped
        launch(3'b101, 32'd100, 32'd7);
        wait_done("divu_poke", 32'd14, DIV_LAT, 1'b1, 1'b1);

        // kill at cycle 10 of a divide
        launch(3'b100, 32'd1000, 32'd3);
        for (int i = 1; i < 10; i++) step();
        check_val("kill_busy_before", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        #1;
        check_val("kill_done_mask", {31'd0, done_o}, 32'd0);
        step();
        kill_i = 1'b0;
        check_val("kill_idle", {31'd0, busy_o}, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done_o === 1'b1) seen++;
                step();
            end
            check_val("kill_no_done", seen, 32'd0);
        end
        check_val("kill_result", result_o, last_res);

        // kill together with start in IDLE drops the request
        op_i       = 3'b101;
        operand1_i = 32'd8;
        operand2_i = 32'd2;
        start_i    = 1'b1;
        kill_i     = 1'b1;
        step();
        start_i = 1'b0;
        kill_i  = 1'b0;
        check_val("kill_start_drop", {31'd0, busy_o}, 32'd0);

        // reset in the middle of a divide
        launch(3'b101, 32'd77, 32'd5);
        for (int i = 1; i < 6; i++) step();
        rst = 1'b0;
        step();
        check_val("mrst_busy", {31'd0, busy_o}, 32'd0);
        check_val("mrst_done", {31'd0, done_o}, 32'd0);
        check_val("mrst_result", result_o, 32'd0);
        rst = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done_o === 1'b1) seen++;
                step();
            end
            check_val("mrst_no_done", seen, 32'd0);
        end

        run_op("divu_after",  3'b101, 32'd100,      32'd7,        32'd14,        DIV_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
